// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for the ALU instruction sequencer.
package alu_pkg;

    localparam int ALU_W       = 16;
    localparam int ALU_DEPTH   = 8;
    localparam int ALU_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE
    } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous instruction FIFO; read data is the registered head slot,
// so a pushed word is only visible after the push edge.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    // a pop on the same edge frees the slot, so a push while full is taken
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Feeds queued instruction words to a multi-cycle ALU one at a time,
// captures results and abandons instructions whose done never arrives.
module alu_instr_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = ALU_DEPTH,
    parameter int W       = ALU_W,
    parameter int TIMEOUT = ALU_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] DIN,
    output logic         run,
    input  logic         done,
    input  logic [W-1:0] G,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         busy,
    output logic         timeout_err,
    output logic [7:0]   issued_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] WD_ONE  = TW'(1);

    seq_state_t             state;
    seq_state_t             state_nxt;
    logic                   pop;
    logic                   wd_fire;
    logic [W-1:0]           head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [TW-1:0]          wcnt;
    logic                   have_word;

    sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (pop),
        .wdata (wr_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign have_word    = (fifo_count != '0);
    assign run          = (state == ISSUE);
    assign result_valid = (state == CAPTURE);
    assign busy         = (state != IDLE);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        wd_fire   = 1'b0;
        unique case (state)
            IDLE: begin
                if (have_word) begin
                    state_nxt = ISSUE;
                    pop       = 1'b1;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (done) begin
                    state_nxt = CAPTURE;
                end else if (wcnt == WD_LAST) begin
                    state_nxt = IDLE;
                    wd_fire   = 1'b1;
                end
            end
            CAPTURE: begin
                if (have_word) begin
                    state_nxt = ISSUE;
                    pop       = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            DIN         <= '0;
            result      <= '0;
            issued_cnt  <= '0;
            timeout_err <= 1'b0;
            wcnt        <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                DIN <= head;
            end
            if (state == ISSUE) begin
                wcnt <= '0;
            end else if (state == WAIT) begin
                wcnt <= wcnt + WD_ONE;
            end
            if (state == WAIT && done) begin
                result     <= G;
                issued_cnt <= issued_cnt + 8'd1;
            end
            if (wd_fire) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench: issued words and ALU results are queued when produced
// and popped by a monitor whenever run or result_valid is seen.
module tb_alu_instr_sequencer;

    localparam int W       = 16;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [W-1:0] g;
        logic [7:0]   cnt;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         full;
    logic         empty;
    logic [W-1:0] DIN;
    logic         run;
    logic         done;
    logic [W-1:0] G;
    logic [W-1:0] result;
    logic         result_valid;
    logic         busy;
    logic         timeout_err;
    logic [7:0]   issued_cnt;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    logic [W-1:0] issue_q[$];
    res_t         res_q[$];
    int           run_cyc[$];
    logic [7:0]   exp_cnt = 8'd0;
    int           gen     = 0;

    int           lat        = 3;
    bit           hang       = 1'b0;
    bit           hold       = 1'b0;
    bit           g_force_en = 1'b0;
    logic [W-1:0] g_force    = '0;

    alu_instr_sequencer #(
        .DEPTH   (DEPTH),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .DIN          (DIN),
        .run          (run),
        .done         (done),
        .G            (G),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .issued_cnt   (issued_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [W-1:0] w, input bit accept);
        wr_en   = 1'b1;
        wr_data = w;
        if (accept) issue_q.push_back(w);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!busy && empty) break;
        end
        chk(name, {31'b0, (k < 2000)}, 32'd1);
    endtask

    // Monitor: every run must carry the oldest accepted word, every
    // result_valid the oldest ALU answer with its completion count.
    always @(negedge clk) begin
        if (!rst) begin
            if (run) begin
                run_cyc.push_back(cyc);
                if (issue_q.size() == 0) begin
                    chk("run_unexpected", {31'b0, run}, 32'd0);
                end else begin
                    chk("din", DIN, issue_q.pop_front());
                end
            end
            if (result_valid) begin
                if (res_q.size() == 0) begin
                    chk("rv_unexpected", {31'b0, result_valid}, 32'd0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("result", result, r.g);
                    chk("issued_cnt", issued_cnt, r.cnt);
                end
            end
        end
    end

    // ALU model: answers each run lat+1 cycles later unless hung.
    initial begin
        done = 1'b0;
        G    = '0;
        forever begin
            @(negedge clk);
            if (run && !rst && !hang) begin
                int my_gen;
                int k;
                my_gen = gen;
                k = 0;
                while (hold && k < 5000) begin
                    @(negedge clk);
                    k++;
                end
                repeat (lat + 1) @(negedge clk);
                if (gen == my_gen) begin
                    G = g_force_en ? g_force : W'($urandom);
                    done = 1'b1;
                    exp_cnt = exp_cnt + 8'd1;
                    res_q.push_back('{G, exp_cnt});
                    @(negedge clk);
                    done = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] saved;
        logic [7:0]   saved_cnt;
        int           k;
        bit           hit;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_run", {31'b0, run}, 32'd0);
        chk("rst_din", DIN, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_cnt", issued_cnt, 32'd0);
        chk("rst_tout", {31'b0, timeout_err}, 32'd0);

        // single instruction with a fixed ALU answer
        lat        = 3;
        g_force_en = 1'b1;
        g_force    = 16'h0002;
        push(16'h0101, 1'b1);
        wait_idle("single_idle");
        chk("single_result", result, 32'h0002);
        chk("single_cnt", issued_cnt, 32'd1);
        g_force_en = 1'b0;

        // back-to-back issue spacing
        run_cyc.delete();
        push(16'hE733, 1'b1);
        push(16'h8180, 1'b1);
        push(16'hC140, 1'b1);
        wait_idle("b2b_idle");
        chk("b2b_runs", run_cyc.size(), 32'd3);
        if (run_cyc.size() == 3) begin
            chk("b2b_sep1", run_cyc[1] - run_cyc[0], 32'd6);
            chk("b2b_sep2", run_cyc[2] - run_cyc[1], 32'd6);
        end
        chk("b2b_cnt", issued_cnt, 32'd4);
        chk("b2b_empty", {31'b0, empty}, 32'd1);

        // watchdog
        hang      = 1'b1;
        saved     = result;
        saved_cnt = issued_cnt;
        run_cyc.delete();
        push(16'h4101, 1'b1);
        hit = 1'b0;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (timeout_err) begin
                hit = 1'b1;
                break;
            end
        end
        chk("tout_seen", {31'b0, hit}, 32'd1);
        if (hit && run_cyc.size() == 1) begin
            chk("tout_latency", cyc - run_cyc[0], 32'd16);
        end
        chk("tout_idle", {31'b0, busy}, 32'd0);
        chk("tout_result", result, saved);
        chk("tout_cnt", issued_cnt, saved_cnt);
        hang = 1'b0;
        push(16'h2103, 1'b1);
        wait_idle("tout_next_idle");
        chk("tout_sticky", {31'b0, timeout_err}, 32'd1);
        chk("tout_next_cnt", issued_cnt, saved_cnt + 8'd1);

        // fill while stalled in WAIT, drop the ninth, push+pop while full
        lat  = 1;
        hold = 1'b1;
        push(16'hA000, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            push(W'($urandom), 1'b1);
        end
        chk("fill_full", {31'b0, full}, 32'd1);
        push(16'hDEAD, 1'b0);
        chk("drop_full", {31'b0, full}, 32'd1);
        chk("drop_busy", {31'b0, busy}, 32'd1);
        hold = 1'b0;
        hit  = 1'b0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (result_valid) begin
                push(16'h5A5A, 1'b1);
                hit = 1'b1;
                break;
            end
        end
        chk("pp_seen", {31'b0, hit}, 32'd1);
        chk("pp_full", {31'b0, full}, 32'd1);
        wait_idle("fill_drain");
        chk("fill_queues", issue_q.size() + res_q.size(), 32'd0);
        chk("fill_cnt", issued_cnt, exp_cnt);

        // reset during WAIT with three words queued
        hang = 1'b1;
        push(16'h1111, 1'b1);
        push(16'h2222, 1'b1);
        push(16'h3333, 1'b1);
        push(16'h4444, 1'b1);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        issue_q.delete();
        res_q.delete();
        exp_cnt = 8'd0;
        gen++;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_empty", {31'b0, empty}, 32'd1);
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_din", DIN, 32'd0);
        chk("mrst_result", result, 32'd0);
        chk("mrst_cnt", issued_cnt, 32'd0);
        chk("mrst_tout", {31'b0, timeout_err}, 32'd0);
        chk("mrst_rv", {31'b0, result_valid}, 32'd0);
        done = 1'b1;
        G    = 16'h1234;
        @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_done_result", result, 32'd0);
        chk("late_done_busy", {31'b0, busy}, 32'd0);
        chk("late_done_empty", {31'b0, empty}, 32'd1);
        hang = 1'b0;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            lat = $urandom_range(0, 4);
            if ($urandom_range(0, 2) == 0 && issue_q.size() < DEPTH) begin
                push(W'($urandom), 1'b1);
            end else begin
                @(negedge clk);
            end
        end
        wait_idle("rand_idle");
        chk("rand_queues", issue_q.size() + res_q.size(), 32'd0);
        chk("rand_cnt", issued_cnt, exp_cnt);
        chk("rand_tout", {31'b0, timeout_err}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu_instr_sequencer.md
ALU_INSTR_SEQUENCER -- requirements
Module: alu_instr_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning instruction FIFO entries (power of two, >= 2).
REQ-002 The block SHALL have parameter W, default 16, meaning instruction/result word width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of WAIT cycles before the watchdog fires.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 wr_en  input  1  host push strobe for the instruction FIFO.
REQ-008 wr_data  input  W  instruction word to push.
REQ-009 full  output  1  FIFO holds DEPTH entries.
REQ-010 empty  output  1  FIFO holds 0 entries.
REQ-011 DIN  output  W  instruction word presented to the ALU.
REQ-012 run  output  1  one-cycle start pulse to the ALU.
REQ-013 done  input  1  ALU completion indication.
REQ-014 G  input  W  ALU result bus.
REQ-015 result  output  W  last captured ALU result.
REQ-016 result_valid  output  1  one-cycle pulse when result is updated.
REQ-017 busy  output  1  high in every state other than IDLE.
REQ-018 timeout_err  output  1  sticky watchdog flag.
REQ-019 issued_cnt  output  8  count of completed instructions, wraps from 255 to 0.

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE, WAIT and CAPTURE.
REQ-021 IDLE -> ISSUE when FIFO not empty; the head word SHALL be popped into the DIN register on that edge.
REQ-022 ISSUE: run SHALL be 1 for exactly this one cycle, with DIN valid; next state is WAIT.
REQ-023 DIN SHALL be held stable from ISSUE until leaving CAPTURE.
REQ-024 WAIT: done SHALL be ignored in the ISSUE cycle and sampled only in WAIT; done=1 -> CAPTURE.
REQ-025 CAPTURE: result SHALL load G on the edge entering CAPTURE; result_valid=1 for one cycle; issued_cnt SHALL increment by 1.
REQ-026 After CAPTURE the FSM SHALL go to ISSUE, popping the next word, if the FIFO is not empty, else to IDLE; a back-to-back issue therefore occurs every 3 cycles plus the ALU latency.
REQ-027 Watchdog: the WAIT cycle counter SHALL reach TIMEOUT without done -> timeout_err=1 (sticky until rst), instruction abandoned, result unchanged, issued_cnt unchanged, next state IDLE.
REQ-028 FIFO push SHALL occur when wr_en=1 and not full; a push while full SHALL be dropped with no state change.
REQ-029 A simultaneous push and pop SHALL leave the occupancy unchanged, and the push SHALL be accepted even when full at that edge.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from an occupancy count of log2(DEPTH)+1 bits.
REQ-031 A push into an empty FIFO SHALL reach DIN no earlier than the cycle after the push, i.e. there is no fall-through.

Reset
REQ-032 rst=1 at a clock edge SHALL force: state IDLE, FIFO empty (pointers and count 0), DIN=0, run=0, result=0, result_valid=0, busy=0, timeout_err=0, issued_cnt=0.
REQ-033 A reset mid-operation (ISSUE/WAIT/CAPTURE) SHALL discard the in-flight instruction and all queued words.
REQ-034 A done that arrives after reset SHALL be ignored.
REQ-035 rst SHALL take priority over wr_en.

Structure
REQ-036 The state encoding (IDLE/ISSUE/WAIT/CAPTURE) and the default W/DEPTH/TIMEOUT constants SHALL live in a shared package, alu_pkg.
REQ-037 The FIFO SHALL be one sub-module, sync_fifo (push/pop/full/empty/count); the FSM, watchdog and counters SHALL stay in the top.

Verification
REQ-038 Reset then push 16'h0101 -> run pulses for 1 cycle with DIN=16'h0101; done with G=16'h0002 three cycles later -> result=16'h0002, result_valid for 1 cycle, issued_cnt=1.
REQ-039 Push 16'hE733, 16'h8180, 16'hC140 back-to-back; the ALU model asserts done 3 cycles after each run -> three run pulses in order, each separated by 6 cycles, issued_cnt=3, empty=1 at the end.
REQ-040 Push 9 words with DEPTH=8 and the FSM stalled in WAIT -> full=1 after 8 words, the 9th is dropped, and exactly 8 instructions are later issued.
REQ-041 Push 16'h4101 and never assert done -> timeout_err=1 after 15 WAIT cycles, FSM IDLE, result unchanged; the next pushed word 16'h2103 still issues normally.
REQ-042 Assert rst during WAIT with 3 words queued -> all outputs at reset values next cycle; a late done produces no result_valid; empty=1.
REQ-043 Push and pop in the same cycle while full -> occupancy stays DEPTH and word order is preserved.
